// File: rtl/branch_predict_choose_param_if.sv
// Pipeline-side signal bundle for the tournament chooser: fetch/MEM indexing,
// pipeline control, training flags and the registered choice back to ID.
interface branch_predict_choose_param_if #(
   parameter int GHR_W = 10
);
   logic             flushD;
   logic             flushE;
   logic             flushM;
   logic             stallD;
   logic [31:0]      pcF;
   logic [GHR_W-1:0] ghrF;
   logic [31:0]      pcM;
   logic [GHR_W-1:0] ghrM;
   logic             branchM;
   logic             global_errorM;
   logic             local_errorM;
   logic             pred_chooseD;
   logic             init_busy;

   modport master (
      output flushD, flushE, flushM, stallD,
      output pcF, ghrF, pcM, ghrM,
      output branchM, global_errorM, local_errorM,
      input  pred_chooseD, init_busy
   );

   modport slave (
      input  flushD, flushE, flushM, stallD,
      input  pcF, ghrF, pcM, ghrM,
      input  branchM, global_errorM, local_errorM,
      output pred_chooseD, init_busy
   );
endinterface

// File: rtl/branch_predict_choose_param.sv
// Tournament chooser: a table of saturating counters picks global (MSB=1) or
// local (MSB=0) prediction per branch. Indexed at fetch, choice registered into
// ID, trained from MEM-stage misprediction flags. After reset a sequential
// clear walks the table, writing the weakly-global value into every entry.
module branch_predict_choose_param #(
   parameter int INDEX_W   = 10,
   parameter int CNT_W     = 2,
   parameter int PC_LSB    = 2,
   parameter int HASH_MODE = 0,
   parameter int GHR_W     = 10
) (
   input logic clk,
   input logic rst,
   branch_predict_choose_param_if.slave bus
);

   localparam int DEPTH = 2 ** INDEX_W;
   localparam logic [CNT_W-1:0] WG  = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

   typedef enum logic {INIT, READY} stateT;

   stateT              state;
   stateT              stateNext;
   logic [INDEX_W-1:0] clrPtr;
   logic [INDEX_W-1:0] clrPtrNext;
   logic               initWrite;

   logic [CNT_W-1:0]   cpht [DEPTH];

   logic [INDEX_W-1:0] idxF;
   logic [INDEX_W-1:0] idxM;
   logic [CNT_W-1:0]   ctrM;
   logic [CNT_W-1:0]   updVal;
   logic               updEn;
   logic               predF;
   logic               predD;

   // Only a slice of each PC/history is used for indexing.
   logic unusedBits;
   assign unusedBits = ^{bus.pcF, bus.pcM, bus.ghrF, bus.ghrM};

   // Index formation: PC slice, optionally hashed with the low history bits.
   generate
      if (HASH_MODE == 1) begin : gHashIdx
         assign idxF = bus.pcF[PC_LSB +: INDEX_W] ^ bus.ghrF[INDEX_W-1:0];
         assign idxM = bus.pcM[PC_LSB +: INDEX_W] ^ bus.ghrM[INDEX_W-1:0];
      end else begin : gPlainIdx
         assign idxF = bus.pcF[PC_LSB +: INDEX_W];
         assign idxM = bus.pcM[PC_LSB +: INDEX_W];
      end
   endgenerate

   // Clear-FSM state register; reset at any time restarts the walk at entry 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= INIT;
         clrPtr <= '0;
      end else begin
         state  <= stateNext;
         clrPtr <= clrPtrNext;
      end
   end

   // Clear-FSM next state: one entry per cycle, READY after the last entry.
   always_comb begin
      stateNext  = state;
      clrPtrNext = clrPtr;
      initWrite  = 1'b0;
      case (state)
         INIT: begin
            initWrite  = 1'b1;
            clrPtrNext = clrPtr + 1'b1;
            if (&clrPtr) begin
               stateNext = READY;
            end
         end
         READY: begin
            initWrite = 1'b0;
         end
      endcase
   end

   // Training: saturating step toward whichever predictor was right.
   always_comb begin
      ctrM   = cpht[idxM];
      updVal = ctrM;
      updEn  = 1'b0;
      if (state == READY && !rst && bus.branchM) begin
         case ({bus.global_errorM, bus.local_errorM})
            2'b10: begin
               updEn = 1'b1;
               if (ctrM != '0) begin
                  updVal = ctrM - 1'b1;
               end
            end
            2'b01: begin
               updEn = 1'b1;
               if (ctrM != MAX) begin
                  updVal = ctrM + 1'b1;
               end
            end
            default: begin
               updEn = 1'b0;
            end
         endcase
      end
   end

   // Fetch read with write-first bypass from a same-cycle update to that entry.
   always_comb begin
      predF = cpht[idxF][CNT_W-1];
      if (updEn && (idxM == idxF)) begin
         predF = updVal[CNT_W-1];
      end
   end

   // Table storage: clear writes during INIT, training writes when READY.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (initWrite) begin
            cpht[clrPtr] <= WG;
         end else if (updEn) begin
            cpht[idxM] <= updVal;
         end
      end
   end

   // F->D choice register: flush beats stall; forced to local while clearing.
   always_ff @(posedge clk) begin
      if (rst || bus.flushD || bus.flushE || bus.flushM) begin
         predD <= 1'b0;
      end else if (state == INIT) begin
         predD <= 1'b0;
      end else if (!bus.stallD) begin
         predD <= predF;
      end
   end

   assign bus.pred_chooseD = predD;
   assign bus.init_busy    = (state == INIT);

endmodule

// File: tb/tb_branch_predict_choose_param.sv
// Bench for the tournament chooser: one plain-index and one hashed-index
// instance share stimulus; a counter-array model checks both every cycle.
module tb_branch_predict_choose_param;

   localparam int IW    = 4;
   localparam int CW    = 2;
   localparam int GW    = 4;
   localparam int DEPTH = 16;
   localparam int MAXC  = 3;
   localparam int WGC   = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   branch_predict_choose_param_if #(.GHR_W(GW)) if0 ();
   branch_predict_choose_param_if #(.GHR_W(GW)) if1 ();

   assign if1.flushD        = if0.flushD;
   assign if1.flushE        = if0.flushE;
   assign if1.flushM        = if0.flushM;
   assign if1.stallD        = if0.stallD;
   assign if1.pcF           = if0.pcF;
   assign if1.ghrF          = if0.ghrF;
   assign if1.pcM           = if0.pcM;
   assign if1.ghrM          = if0.ghrM;
   assign if1.branchM       = if0.branchM;
   assign if1.global_errorM = if0.global_errorM;
   assign if1.local_errorM  = if0.local_errorM;

   branch_predict_choose_param #(
      .INDEX_W(IW), .CNT_W(CW), .PC_LSB(2), .HASH_MODE(0), .GHR_W(GW)
   ) dutPlain (
      .clk(clk), .rst(rst), .bus(if0)
   );

   branch_predict_choose_param #(
      .INDEX_W(IW), .CNT_W(CW), .PC_LSB(2), .HASH_MODE(1), .GHR_W(GW)
   ) dutHash (
      .clk(clk), .rst(rst), .bus(if1)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: counter values per instance, init countdown, choice reg.
   int   cnt [2][DEPTH];
   int   initLeft = 0;
   logic mPred [2];
   bit   valid = 0;

   typedef struct {
      logic        branch;
      logic        g;
      logic        l;
      logic        stall;
      logic        fD;
      logic        fE;
      logic        fM;
      logic [31:0] pcM;
      logic [31:0] pcF;
      logic        exp0;
   } vecT;

   vecT vt[$];

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: actual=%b expected=%b", name, $time, act, exp);
      end
   endtask

   task automatic chkInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   function automatic int idxOf(input logic [31:0] pc, input logic [GW-1:0] ghr, input int h);
      int i;
      i = int'(pc >> 2) & (DEPTH - 1);
      if (h != 0) i = i ^ int'(ghr);
      return i & (DEPTH - 1);
   endfunction

   function automatic vecT mk(input logic b, input logic g, input logic l, input logic st,
                              input logic fD, input logic fE, input logic fM,
                              input logic [31:0] pcM, input logic [31:0] pcF, input logic e);
      vecT v;
      v.branch = b; v.g = g; v.l = l; v.stall = st;
      v.fD = fD; v.fE = fE; v.fM = fM;
      v.pcM = pcM; v.pcF = pcF; v.exp0 = e;
      return v;
   endfunction

   task automatic setIdle();
      if0.flushD = 0; if0.flushE = 0; if0.flushM = 0; if0.stallD = 0;
      if0.pcF = '0; if0.ghrF = '0; if0.pcM = '0; if0.ghrM = '0;
      if0.branchM = 0; if0.global_errorM = 0; if0.local_errorM = 0;
   endtask

   // Advance the model by one edge from the current inputs, then compare.
   task automatic tick();
      logic fl;
      fl = if0.flushD | if0.flushE | if0.flushM;
      if (rst) begin
         valid    = 1;
         initLeft = DEPTH;
         for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < DEPTH; e++) cnt[d][e] = WGC;
            mPred[d] = 1'b0;
         end
      end else if (initLeft > 0) begin
         initLeft--;
         mPred[0] = 1'b0;
         mPred[1] = 1'b0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            int iM;
            int iF;
            iM = idxOf(if0.pcM, if0.ghrM, d);
            iF = idxOf(if0.pcF, if0.ghrF, d);
            if (if0.branchM && (if0.global_errorM != if0.local_errorM)) begin
               if (if0.global_errorM) cnt[d][iM] = (cnt[d][iM] > 0) ? cnt[d][iM] - 1 : 0;
               else                   cnt[d][iM] = (cnt[d][iM] < MAXC) ? cnt[d][iM] + 1 : MAXC;
            end
            if (fl)              mPred[d] = 1'b0;
            else if (!if0.stallD) mPred[d] = (cnt[d][iF] >= WGC);
         end
      end
      @(posedge clk);
      #1;
      if (valid) begin
         chk("busy_plain", if0.init_busy, initLeft > 0);
         chk("busy_hash",  if1.init_busy, initLeft > 0);
         chk("pred_plain", if0.pred_chooseD, mPred[0]);
         chk("pred_hash",  if1.pred_chooseD, mPred[1]);
      end
   endtask

   task automatic doReset();
      int n;
      setIdle();
      rst = 1;
      tick();
      rst = 0;
      chk("busy_after_rst", if0.init_busy, 1'b1);
      n = 0;
      while (if0.init_busy === 1'b1 && n < 40) begin
         chk("pred_during_init", if0.pred_chooseD, 1'b0);
         tick();
         n++;
      end
      chkInt("init_len", n, DEPTH);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      setIdle();
      repeat (2) @(posedge clk);
      #1;

      // Reset / init length, then first fetch reads weakly-global.
      doReset();
      tick();
      chk("first_fetch_wg", if0.pred_chooseD, 1'b1);

      // Table: saturation, bypass, stall/flush priority, hold codes.
      vt.push_back(mk(1,1,0, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(1,1,0, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(0,0,0, 0,0,0,0, 32'h40, 32'h40, 0));
      vt.push_back(mk(1,1,0, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(0,0,0, 0,0,0,0, 32'h40, 32'h40, 0));
      vt.push_back(mk(1,0,1, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(0,0,0, 0,0,0,0, 32'h40, 32'h40, 0));
      vt.push_back(mk(1,0,1, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(1,0,1, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(1,0,1, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(0,0,0, 0,0,0,0, 32'h40, 32'h40, 1));
      vt.push_back(mk(1,1,0, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(1,1,0, 0,0,0,0, 32'h40, 32'h40, 0));
      vt.push_back(mk(0,0,0, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(0,0,0, 1,0,0,0, 32'h40, 32'h40, 1));
      vt.push_back(mk(0,0,0, 1,0,1,0, 32'h40, 32'h44, 0));
      vt.push_back(mk(0,0,0, 0,0,0,0, 32'h40, 32'h44, 1));
      vt.push_back(mk(1,1,1, 0,0,0,0, 32'h44, 32'h44, 1));
      vt.push_back(mk(1,0,0, 0,0,0,0, 32'h44, 32'h44, 1));
      vt.push_back(mk(0,0,0, 0,1,0,0, 32'h44, 32'h44, 0));
      vt.push_back(mk(0,0,0, 0,0,0,1, 32'h44, 32'h44, 0));
      vt.push_back(mk(0,0,0, 0,0,0,0, 32'h44, 32'h44, 1));
      foreach (vt[i]) begin
         if0.branchM = vt[i].branch; if0.global_errorM = vt[i].g; if0.local_errorM = vt[i].l;
         if0.stallD = vt[i].stall; if0.flushD = vt[i].fD; if0.flushE = vt[i].fE;
         if0.flushM = vt[i].fM; if0.pcM = vt[i].pcM; if0.pcF = vt[i].pcF;
         tick();
         chk($sformatf("vec%0d", i), if0.pred_chooseD, vt[i].exp0);
      end

      // Hash collision: pc 0x10/ghr 0x8 and pc 0x20/ghr 0x4 share an entry.
      doReset();
      if0.branchM = 1; if0.global_errorM = 1; if0.local_errorM = 0;
      if0.pcM = 32'h10; if0.ghrM = 4'h8; if0.pcF = 32'h80; if0.ghrF = 4'h0;
      tick();
      tick();
      if0.branchM = 0; if0.global_errorM = 0;
      if0.pcF = 32'h20; if0.ghrF = 4'h4;
      tick();
      chk("hash_alias_hash", if1.pred_chooseD, 1'b0);
      chk("hash_alias_plain", if0.pred_chooseD, 1'b1);
      if0.pcF = 32'h10; if0.ghrF = 4'h8;
      tick();
      chk("hash_trained_hash", if1.pred_chooseD, 1'b0);
      chk("hash_trained_plain", if0.pred_chooseD, 1'b0);

      // Reset during INIT restarts the full walk; INIT-time updates are dropped.
      setIdle();
      rst = 1;
      tick();
      rst = 0;
      if0.branchM = 1; if0.global_errorM = 1; if0.local_errorM = 0;
      for (int i = 0; i < 7; i++) begin
         if0.pcM = 32'(i << 2);
         tick();
      end
      rst = 1;
      tick();
      rst = 0;
      begin
         int n;
         n = 0;
         while (if0.init_busy === 1'b1 && n < 40) begin
            if0.pcM = 32'((n % DEPTH) << 2);
            tick();
            n++;
         end
         chkInt("midrst_init_len", n, DEPTH);
      end
      setIdle();
      for (int i = 0; i < DEPTH; i++) begin
         if0.pcF = 32'(i << 2);
         tick();
         chk("midrst_wg_plain", if0.pred_chooseD, 1'b1);
         chk("midrst_wg_hash", if1.pred_chooseD, 1'b1);
      end

      // Random traffic against the model, with occasional resets.
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(149) == 0);
         if0.branchM       = $urandom_range(1);
         if0.global_errorM = $urandom_range(1);
         if0.local_errorM  = $urandom_range(1);
         if0.stallD        = ($urandom_range(4) == 0);
         if0.flushD        = ($urandom_range(15) == 0);
         if0.flushE        = ($urandom_range(15) == 0);
         if0.flushM        = ($urandom_range(15) == 0);
         if0.pcF           = $urandom;
         if0.ghrF          = 4'($urandom_range(15));
         if ($urandom_range(2) == 0) begin
            if0.pcM  = if0.pcF;
            if0.ghrM = if0.ghrF;
         end else begin
            if0.pcM  = $urandom;
            if0.ghrM = 4'($urandom_range(15));
         end
         tick();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predict_choose_param.md
Name: branch_predict_choose_param

Overview:
- Parametrised tournament chooser: a choice pattern history table (CPHT) of saturating counters selects global vs local predictor per branch.
- Indexed in IF; the choice is registered into ID (pred_chooseD); the table is trained from MEM-stage error flags.
- Generalises the fixed 2-bit, 20-bit-index chooser with:
  - configurable depth and counter width;
  - optional PC⊕history hashing;
  - multi-cycle table-clear FSM replacing the single-cycle full-table reset;
  - write-first bypass when the same entry is read and updated in one cycle.

Parameters:
INDEX_W, 10, log2 of CPHT entries (table depth 2^INDEX_W).
CNT_W, 2, counter width in bits (≥2); MSB=1 selects global.
PC_LSB, 2, lowest PC bit used in the index (drops byte offset).
HASH_MODE, 0, 0: index = PC slice; 1: index = PC slice XOR history low INDEX_W bits.
GHR_W, 10, global history width (≥INDEX_W when HASH_MODE=1).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flushD  in  1  flush ID pipeline register
flushE  in  1  flush (clears pred_chooseD as well)
flushM  in  1  flush (clears pred_chooseD as well)
stallD  in  1  hold pred_chooseD
pcF  in  32  fetch PC
ghrF  in  GHR_W  history used at fetch (ignored when HASH_MODE=0)
pcM  in  32  PC of branch in MEM
ghrM  in  GHR_W  history snapshot travelling with the MEM branch
branchM  in  1  MEM instruction is a branch; enables update
global_errorM  in  1  global predictor mispredicted
local_errorM  in  1  local predictor mispredicted
pred_chooseD  out  1  1 = use global, 0 = use local (registered)
init_busy  out  1  1 while the table-clear FSM runs

Behaviour:
- Index:
  - idxF = pcF[PC_LSB+INDEX_W-1:PC_LSB], XOR ghrF[INDEX_W-1:0] if HASH_MODE=1.
  - idxM is formed the same way from pcM/ghrM.
- Init value of every entry: WG = 2^(CNT_W-1) (weakly global). MAX = 2^CNT_W−1.
- FSM states INIT, READY:
  - rst (any state, any cycle) → INIT with clear pointer = 0. Reset mid-INIT restarts from 0.
  - INIT writes WG to entry[ptr] each cycle and increments ptr. After writing entry 2^INDEX_W−1 → READY.
  - INIT lasts exactly 2^INDEX_W cycles after rst deasserts.
  - init_busy=1 in INIT, 0 in READY; reset value 1.
  - In INIT: all updates are dropped, and pred_chooseD is loaded with 0 every cycle regardless of stall.
- Update (READY, branchM=1), applied to entry[idxM]:
  - {g,l}=10 → decrement, saturating at 0 (toward local).
  - {g,l}=01 → increment, saturating at MAX (toward global).
  - {g,l}=00 or 11 → hold.
  - branchM=0 → no write.
- Prediction:
  - predF = MSB of entry[idxF].
  - Write-first bypass: if an update is committed this cycle and idxM==idxF, predF = MSB of the post-update value.
- pred_chooseD register (1-cycle latency F→D):
  - Priority: rst | flushD | flushE | flushM → 0; else INIT → 0; else stallD → hold; else ← predF.
  - Flush and stall in the same cycle: flush wins.
  - Reset value 0.
- Arithmetic: counters are CNT_W bits unsigned, no wrap. Saturation is checked before the ±1.
- Storage is a plain register array, synchronous write; the read is combinational (inferable as distributed RAM).

Test Plan:
- Reset/init (INDEX_W=4): pulse rst 1 cycle → init_busy=1 for exactly 16 cycles then 0; pred_chooseD=0 throughout; first unstalled fetch afterwards gives pred_chooseD=1 (WG MSB).
- Train toward local (CNT_W=2): entry at pcM=0x40 takes two updates {g,l}=10 → counter 2→1→0; fetch pcF=0x40 → pred_chooseD=0; a third 10 update → stays 0. Then 01,01,01 → 1,2,3; a further 01 holds at 3; fetch → 1.
- Bypass: counter=2, same cycle branchM=1 {g,l}=10 with pcM=pcF → pred_chooseD next cycle = 0 (not 1).
- Stall/flush: pred_chooseD=1, stallD=1 while predF=0 → stays 1; assert flushE with stallD=1 → 0 next cycle.
- Hash (HASH_MODE=1, INDEX_W=4): two PCs 0x10 and 0x20 with ghr chosen so idx collide (ghr 0x4/0x8) → training one flips the other's prediction; with HASH_MODE=0 they are independent.
- Reset mid-init: assert rst at init cycle 7 → init_busy stays 1 for a further full 16 cycles; updates issued during INIT leave all entries at WG.
